// File: rtl/ram_pkg.sv
// Shared constants and types for the 64K x 32 data memory.
package ram_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] ram_addr_t;
  typedef logic [DATA_W-1:0] ram_word_t;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } access_e;

  // RW is only meaningful while Enable is high.
  function automatic access_e decode_access(input logic enable, input logic rw);
    if (!enable) return ACC_IDLE;
    return rw ? ACC_READ : ACC_WRITE;
  endfunction

endpackage

// File: rtl/ram.sv
// Single-port synchronous 64K x 32 data memory: one write or registered read per clock.
// Optional build macro RAM_WRITE_THROUGH_EN: write data also appears on Out one cycle later.
module ram
  import ram_pkg::*;
#(
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int DEPTH  = ram_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Enable,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] In,
  output logic [DATA_W-1:0] Out
);

  logic [DATA_W-1:0] Mem [0:DEPTH-1];

  access_e acc;

  always_comb begin
    acc = decode_access(Enable, RW);
  end

  // Storage has no reset; reset only blocks the write in its cycle.
  always_ff @(posedge clk) begin
    if (!rst && acc == ACC_WRITE) begin
      Mem[Address] <= In;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Out <= '0;
    end else if (acc == ACC_READ) begin
      Out <= Mem[Address];
    end
`ifdef RAM_WRITE_THROUGH_EN
    else if (acc == ACC_WRITE) begin
      Out <= In;
    end
`endif
  end

endmodule

// File: tb/tb_ram.sv
// Scoreboarded random and directed bench for ram against an associative-array memory model.
module tb_ram;
  import ram_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      Enable;
  logic      RW;
  ram_addr_t Address;
  ram_word_t In;
  ram_word_t Out;

  always #5 clk = ~clk;

  ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .Enable (Enable),
    .RW     (RW),
    .Address(Address),
    .In     (In),
    .Out    (Out)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ram_word_t exp_q[$];
  string     tag_q[$];
  ram_word_t model[int unsigned];
  ram_word_t exp_out = '0;

  task automatic check(input string name, input ram_word_t act, input ram_word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and record what Out must show after its edge.
  task automatic step(input logic r, input logic en, input logic rw,
                      input ram_addr_t a, input ram_word_t d, input string name);
    @(negedge clk);
    rst = r; Enable = en; RW = rw; Address = a; In = d;
    if (r) begin
      exp_out = '0;
    end else if (en && !rw) begin
      model[int'(a)] = d;
`ifdef RAM_WRITE_THROUGH_EN
      exp_out = d;
`endif
    end else if (en && rw) begin
      exp_out = model.exists(int'(a)) ? model[int'(a)] : 'x;
    end
    exp_q.push_back(exp_out);
    tag_q.push_back(name);
  endtask

  // Called right after a step returns: all earlier edges have settled.
  task automatic check_mem(input ram_addr_t a, input string name);
    check(name, dut.Mem[a], model[int'(a)]);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check(tag_q.pop_front(), Out, exp_q.pop_front());
    end
  end

  function automatic ram_addr_t rand_addr();
    ram_addr_t a;
    if ($urandom_range(0, 3) == 0) a = 16'hFFF8 + ram_addr_t'($urandom_range(0, 7));
    else                           a = ram_addr_t'($urandom_range(0, 15));
    return a;
  endfunction

  ram_word_t seq_vals [7] = '{32'hCCCC00AA, 32'hDDDD00BB, 32'hEEEE00CC, 32'hFFFF00DD,
                              32'hAAAA00EE, 32'hBBBB00FF, 32'hCCCCFFFF};

  initial begin
    rst = 1'b1; Enable = 1'b0; RW = 1'b0; Address = '0; In = '0;

    step(1'b1, 1'b0, 1'b0, 16'h0000, 32'h0, "reset_a");
    step(1'b1, 1'b0, 1'b0, 16'h0000, 32'h0, "reset_b");

    step(1'b0, 1'b1, 1'b0, 16'h0000, 32'hAAAAAAAA, "ovw_wr1");
    step(1'b0, 1'b1, 1'b0, 16'h0000, 32'hABBBAAAA, "ovw_wr2");
    step(1'b0, 1'b1, 1'b1, 16'h0000, 32'h0,        "ovw_rd");

    for (int unsigned i = 0; i < 7; i++)
      step(1'b0, 1'b1, 1'b0, ram_addr_t'(i + 1), seq_vals[i], "seq_wr");
    for (int unsigned i = 0; i < 7; i++)
      step(1'b0, 1'b1, 1'b1, ram_addr_t'(i + 1), 32'h0, $sformatf("seq_rd%0d", i + 1));
    step(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, "idle");
    for (int unsigned i = 0; i < 8; i++)
      check_mem(ram_addr_t'(i), $sformatf("mem_word%0d", i));

    step(1'b0, 1'b1, 1'b1, 16'h0003, 32'h0,        "hold_rd");
    step(1'b0, 1'b0, 1'b0, 16'h0003, 32'h12345678, "hold_idle");
    step(1'b0, 1'b0, 1'b0, 16'h0003, 32'h12345678, "hold_idle2");
    check_mem(16'h0003, "hold_mem3");

    step(1'b1, 1'b1, 1'b0, 16'h0002, 32'h55555555, "rst_wr_out");
    step(1'b0, 1'b0, 1'b0, 16'h0002, 32'h0,        "post_rst_idle");
    check_mem(16'h0002, "rst_wr_mem2");
    step(1'b0, 1'b1, 1'b1, 16'h0002, 32'h0,        "rst_wr_rd2");

    step(1'b0, 1'b1, 1'b0, 16'hFFFF, 32'hDEADBEEF, "top_wr");
    step(1'b0, 1'b1, 1'b1, 16'hFFFF, 32'h0,        "top_rd");

    for (int unsigned n = 0; n < 400; n++) begin
      logic      r, en, rw;
      ram_addr_t a;
      r  = ($urandom_range(0, 31) == 0);
      en = ($urandom_range(0, 3) != 0);
      rw = $urandom_range(0, 1) == 1;
      a  = rand_addr();
      if (en && rw && !model.exists(int'(a))) rw = 1'b0;
      step(r, en, rw, a, $urandom(), "rand");
    end

    step(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, "tail_idle");
    foreach (model[k]) check_mem(ram_addr_t'(k), $sformatf("final_mem_%04h", k));

    repeat (3) @(posedge clk);
    #2;
    check("queue_drain", ram_word_t'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
